// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register-file write port between the
//                writeback stage (port A) and a long-latency unit (port B).
//                B results are buffered in a small FIFO and drained when A
//                leaves the port idle, when a starvation limit is reached, or
//                when an A write would overtake a buffered write to the same
//                register (WAW ordering). pend_hit_* flags source registers
//                that still have a buffered, unwritten result.
//  Ports       : clk, reset            clock / async active-high reset
//                a_valid/addr/data     writeback request, a_ready = accepted
//                b_valid/addr/data     long-latency result, b_ready = accepted
//                rf_we/waddr/wdata     register-file write port
//                rd_addr_1/2           decode source registers
//                pend_hit_1/2          source has a buffered pending write
//                fifo_count            occupied B FIFO entries
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [31:0]              a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_addr,
  input  logic [31:0]              b_data,
  output logic                     b_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               rd_addr_1,
  input  logic [4:0]               rd_addr_2,
  output logic                     pend_hit_1,
  output logic                     pend_hit_2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic w_empty, w_full, w_waw, w_hit1, w_hit2;
  logic w_grant_fifo, w_a_ready, w_push, w_pop;

  always_comb begin
    w_empty = (count_q == '0);
    w_full  = (count_q == FULL_COUNT);
    w_waw   = 1'b0;
    w_hit1  = 1'b0;
    w_hit2  = 1'b0;
    // Only occupied entries count; an entry popped this cycle is still
    // occupied here because the register file has not been written yet.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (addr_q[i] == a_addr)    w_waw  = 1'b1;
        if (addr_q[i] == rd_addr_1) w_hit1 = 1'b1;
        if (addr_q[i] == rd_addr_2) w_hit2 = 1'b1;
      end
    end

    // Grant priority: empty FIFO, starvation, WAW hazard, A request, idle.
    if (w_empty) begin
      w_grant_fifo = 1'b0;
      w_a_ready    = 1'b1;
    end else if (starve_q == STARVE_MAX) begin
      w_grant_fifo = 1'b1;
      w_a_ready    = 1'b0;
    end else if (a_valid && (a_addr != 5'd0) && w_waw) begin
      w_grant_fifo = 1'b1;
      w_a_ready    = 1'b0;
    end else if (a_valid) begin
      w_grant_fifo = 1'b0;
      w_a_ready    = 1'b1;
    end else begin
      w_grant_fifo = 1'b1;
      w_a_ready    = 1'b1;
    end

    // B writes to r0 are swallowed without occupying an entry.
    w_push = b_valid && !w_full && (b_addr != 5'd0);
    w_pop  = w_grant_fifo;

    // Outputs forced idle while reset is asserted.
    a_ready    = !reset && w_a_ready;
    b_ready    = !reset && (!w_full || (b_addr == 5'd0));
    pend_hit_1 = !reset && w_hit1 && (rd_addr_1 != 5'd0);
    pend_hit_2 = !reset && w_hit2 && (rd_addr_2 != 5'd0);
    fifo_count = count_q;

    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!reset) begin
      if (w_grant_fifo) begin
        rf_we    = 1'b1;
        rf_waddr = addr_q[rd_ptr_q];
        rf_wdata = data_q[rd_ptr_q];
      end else if (a_valid && (a_addr != 5'd0)) begin
        rf_we    = 1'b1;
        rf_waddr = a_addr;
        rf_wdata = a_data;
      end
    end

    // Next-state for the FIFO.
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (w_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = b_addr;
      data_d[wr_ptr_q]  = b_data;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (!w_push && w_pop) count_d = count_q - CW'(1);

    // Count cycles in which buffered data waits behind A grants.
    if (w_empty || w_pop)          starve_d = '0;
    else if (starve_q < STARVE_MAX) starve_d = starve_q + SW'(1);
    else                           starve_d = starve_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr, rd_addr_1, rd_addr_2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_we, pend_hit_1, pend_hit_2;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_count;
  logic [31:0] shadow_rf [32];

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .pend_hit_1(pend_hit_1), .pend_hit_2(pend_hit_2),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Register-file image built from the write port.
  always @(posedge clk) begin
    if (rf_we) shadow_rf[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks 2ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow_rf[i] = 32'd0;
    reset = 1'b1; rd_addr_1 = 5'd0; rd_addr_2 = 5'd0;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    cyc();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_count", fifo_count, 0);
    cyc();
    reset = 1'b0;

    // 1: A write with empty FIFO goes straight through.
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    check("t1_a_ready", a_ready, 1);
    check("t1_rf_we", rf_we, 1);
    check("t1_waddr", rf_waddr, 5);
    check("t1_wdata", rf_wdata, 32'h11);
    cyc();

    // 2: B pushes drain one cycle later while A idle.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hAA);
    check("t2_b_ready0", b_ready, 1);
    check("t2_we0", rf_we, 0);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBB);
    check("t2_b_ready1", b_ready, 1);
    check("t2_count1", fifo_count, 1);
    check("t2_waddr8", rf_waddr, 8);
    check("t2_wdata8", rf_wdata, 32'hAA);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t2_count2", fifo_count, 1);
    check("t2_waddr9", rf_waddr, 9);
    check("t2_wdata9", rf_wdata, 32'hBB);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t2_empty", fifo_count, 0);
    check("t2_idle_we", rf_we, 0);
    cyc();

    // 3: fill FIFO behind continuous A traffic; starvation forces a drain.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'd1, 32'h100 + c, 1'b1, 5'(10 + c), 32'hB0 + c);
      check("t3_fill_count", fifo_count, c);
      check("t3_fill_a_ready", a_ready, 1);
      check("t3_fill_waddr", rf_waddr, 1);
      cyc();
    end
    drive(1'b1, 5'd1, 32'h104, 1'b1, 5'd14, 32'hEE);
    check("t3_full_b_ready", b_ready, 0);
    check("t3_full_count", fifo_count, 4);
    cyc();
    drive(1'b1, 5'd1, 32'h105, 1'b1, 5'd0, 32'hEE);
    check("t3_r0_b_ready", b_ready, 1);
    cyc();
    for (int c = 6; c < 9; c++) begin
      drive(1'b1, 5'd1, 32'h100 + c, 1'b0, 5'd0, 32'd0);
      check("t3_wait_a_ready", a_ready, 1);
      cyc();
    end
    drive(1'b1, 5'd1, 32'h109, 1'b0, 5'd0, 32'd0);
    check("t3_starve_a_ready", a_ready, 0);
    check("t3_starve_waddr", rf_waddr, 10);
    check("t3_starve_wdata", rf_wdata, 32'hB0);
    check("t3_starve_count", fifo_count, 4);
    cyc();
    drive(1'b1, 5'd1, 32'h10A, 1'b0, 5'd0, 32'd0);
    check("t3_after_a_ready", a_ready, 1);
    check("t3_after_count", fifo_count, 3);
    check("t3_after_waddr", rf_waddr, 1);
    cyc();
    for (int c = 1; c < 4; c++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("t3_drain_waddr", rf_waddr, 10 + c);
      check("t3_drain_wdata", rf_wdata, 32'hB0 + c);
      cyc();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t3_drained", fifo_count, 0);

    // 4: WAW ordering on r7.
    drive(1'b1, 5'd1, 32'h200, 1'b1, 5'd7, 32'h1);
    cyc();
    drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    check("t4_waw_a_ready", a_ready, 0);
    check("t4_waw_waddr", rf_waddr, 7);
    check("t4_waw_wdata", rf_wdata, 32'h1);
    cyc();
    drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    check("t4_a_ready", a_ready, 1);
    check("t4_wdata", rf_wdata, 32'h2);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t4_final_r7", shadow_rf[7], 32'h2);

    // 5: pending-hit visibility around push and pop of r12.
    rd_addr_1 = 5'd12; rd_addr_2 = 5'd0;
    drive(1'b1, 5'd1, 32'h300, 1'b1, 5'd12, 32'hCC);
    check("t5_push_hit1", pend_hit_1, 0);
    cyc();
    drive(1'b1, 5'd1, 32'h301, 1'b0, 5'd0, 32'd0);
    check("t5_hit1", pend_hit_1, 1);
    check("t5_hit2", pend_hit_2, 0);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t5_pop_hit1", pend_hit_1, 1);
    check("t5_pop_waddr", rf_waddr, 12);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t5_after_hit1", pend_hit_1, 0);
    rd_addr_1 = 5'd0;

    // 6: reset pulse mid-cycle with 3 buffered entries.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd1, 32'h400, 1'b1, 5'(20 + c), 32'hD0 + c);
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("t6_pre_count", fifo_count, 3);
    reset = 1'b1;
    #1;
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_we", rf_we, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rel_we", rf_we, 0);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t6_post_we", rf_we, 0);
    check("t6_post_count", fifo_count, 0);
    check("t6_no_stale_r20", shadow_rf[20], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
